// File: rtl/qp_param_pipe.sv
// qp_param_pipe
//   Pipelined QP / per / rem calculator. It takes one QP request per coding
//   block and returns one result beat per colour component: Y, then Cb and Cr
//   (Y only for 4:0:0). Each beat carries the final Qp, Qp/6 and Qp%6.
//   Results leave through a valid/ready stream with full backpressure.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   in_valid/ready  request handshake; the request fields are latched on accept
//   in_qpy          signed luma QP
//   in_bd_offset    signed QpBdOffset (0..48)
//   in_cb_offset    signed Cb QP offset
//   in_cr_offset    signed Cr QP offset
//   in_chfmt        0=4:0:0 1=4:2:0 2=4:2:2 3=4:4:4
//   out_valid/ready result handshake
//   out_comp        0=Y 1=Cb 2=Cr
//   out_qp          final Qp (low QP_OUT_W bits)
//   out_per         Qp/6
//   out_rem         Qp%6
//   out_last        last beat of the request
module qp_param_pipe #(
   parameter int QP_W     = 8,
   parameter int QPC_MAX  = 57,
   parameter int QP_OUT_W = 8,
   parameter int PER_W    = 5
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic signed [QP_W-1:0]     in_qpy,
   input  logic signed [QP_W-1:0]     in_bd_offset,
   input  logic signed [QP_W-1:0]     in_cb_offset,
   input  logic signed [QP_W-1:0]     in_cr_offset,
   input  logic [1:0]                 in_chfmt,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [1:0]                 out_comp,
   output logic [QP_OUT_W-1:0]        out_qp,
   output logic [PER_W-1:0]           out_per,
   output logic [2:0]                 out_rem,
   output logic                       out_last
);

   // Two guard bits so qpy + offset cannot overflow before clipping.
   localparam int SW = QP_W + 2;
   localparam logic signed [SW-1:0] QPC_HI   = SW'(QPC_MAX);
   localparam logic signed [SW-1:0] LUMA_MAX = SW'(51);
   localparam logic signed [SW-1:0] ZERO     = SW'(0);

   typedef enum logic [1:0] {IDLE, ISS_Y, ISS_CB, ISS_CR} state_t;

   state_t                 state, state_nx;
   logic                   stall, take;
   logic                   issue_vld, issue_last;
   logic [1:0]             issue_comp;
   logic signed [QP_W-1:0] qpy_r, bd_r, cb_r, cr_r;
   logic [1:0]             chfmt_r;
   logic signed [SW-1:0]   qpy_x, bd_x, off_x, sum, qpi, qp_calc;
   logic                   vld_p1, last_p1;
   logic [1:0]             comp_p1;
   logic [QP_OUT_W-1:0]    qp_p1;
   logic [1:0]             open_cnt;

   // 4:2:0 chroma QP table; identity below 30, minus 6 above 42.
   function automatic logic signed [SW-1:0] chroma_map(input logic signed [SW-1:0] q);
      logic signed [SW-1:0] m;
      m = q;
      if (q > SW'(42)) begin
         m = q - SW'(6);
      end else begin
         case (q)
            SW'(30): m = SW'(29);
            SW'(31): m = SW'(30);
            SW'(32): m = SW'(31);
            SW'(33): m = SW'(32);
            SW'(34), SW'(35): m = SW'(33);
            SW'(36), SW'(37): m = SW'(34);
            SW'(38), SW'(39): m = SW'(35);
            SW'(40), SW'(41): m = SW'(36);
            SW'(42): m = SW'(37);
            default: m = q;
         endcase
      end
      return m;
   endfunction

   // Reciprocal multiply: (q*171)>>10 equals q/6 for every q in 0..255.
   function automatic logic [PER_W-1:0] div6(input logic [QP_OUT_W-1:0] q);
      logic [QP_OUT_W+7:0] prod;
      prod = (QP_OUT_W+8)'(q) * (QP_OUT_W+8)'(171);
      return PER_W'(prod >> 10);
   endfunction

   function automatic logic [2:0] rem6(input logic [QP_OUT_W-1:0] q,
                                       input logic [PER_W-1:0] per);
      logic [QP_OUT_W-1:0] r;
      r = q - QP_OUT_W'(QP_OUT_W'(per) * QP_OUT_W'(6));
      return 3'(r);
   endfunction

   assign stall    = out_valid & ~out_ready;
   // Gated by rst_n so in_ready reads 0 while reset is held.
   assign in_ready = rst_n & (state == IDLE) & ~stall;
   assign take     = in_valid & in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx   = state;
      issue_vld  = 1'b0;
      issue_comp = 2'd0;
      issue_last = 1'b0;
      case (state)
         IDLE: begin
            if (take) state_nx = ISS_Y;
         end
         ISS_Y: begin
            issue_vld  = 1'b1;
            issue_comp = 2'd0;
            issue_last = (chfmt_r == 2'd0);
            if (!stall) state_nx = (chfmt_r == 2'd0) ? IDLE : ISS_CB;
         end
         ISS_CB: begin
            issue_vld  = 1'b1;
            issue_comp = 2'd1;
            if (!stall) state_nx = ISS_CR;
         end
         ISS_CR: begin
            issue_vld  = 1'b1;
            issue_comp = 2'd2;
            issue_last = 1'b1;
            if (!stall) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (take) begin
         qpy_r   <= in_qpy;
         bd_r    <= in_bd_offset;
         cb_r    <= in_cb_offset;
         cr_r    <= in_cr_offset;
         chfmt_r <= in_chfmt;
      end
   end

   always_comb begin
      qpy_x = SW'(qpy_r);
      bd_x  = SW'(bd_r);
      off_x = (state == ISS_CB) ? SW'(cb_r) : SW'(cr_r);
      sum   = qpy_x + off_x;
      qpi   = sum;
      if (sum < -bd_x)       qpi = -bd_x;
      else if (sum > QPC_HI) qpi = QPC_HI;
      if (state == ISS_Y)        qp_calc = qpy_x + bd_x;
      else if (qpi < ZERO)       qp_calc = qpi + bd_x;
      else if (chfmt_r == 2'd1)  qp_calc = chroma_map(qpi) + bd_x;
      else                       qp_calc = ((qpi > LUMA_MAX) ? LUMA_MAX : qpi) + bd_x;
   end

   // ---- stage 1: Qp ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1  <= 1'b0;
         comp_p1 <= 2'd0;
         last_p1 <= 1'b0;
      end else if (!stall) begin
         vld_p1  <= issue_vld;
         comp_p1 <= issue_comp;
         last_p1 <= issue_last;
      end
   end

   always_ff @(posedge clk) begin
      if (!stall) qp_p1 <= QP_OUT_W'(qp_calc);
   end

   // ---- stage 2: per/rem, output register ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_comp  <= 2'd0;
         out_last  <= 1'b0;
         out_qp    <= '0;
         out_per   <= '0;
         out_rem   <= 3'd0;
      end else if (!stall) begin
         out_valid <= vld_p1;
         out_comp  <= comp_p1;
         out_last  <= last_p1;
         out_qp    <= qp_p1;
         out_per   <= div6(qp_p1);
         out_rem   <= rem6(qp_p1, div6(qp_p1));
      end
   end

   // Requests accepted but whose last beat has not yet left.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) open_cnt <= 2'd0;
      else        open_cnt <= open_cnt + 2'(take) - 2'(out_valid & out_ready & out_last);
   end

   a_stable: assert property (@(posedge clk) disable iff (!rst_n)
      (out_valid & ~out_ready) |=> $stable({out_valid, out_comp, out_qp, out_per, out_rem, out_last}));
   a_rem: assert property (@(posedge clk) disable iff (!rst_n)
      out_valid |-> (out_rem < 3'd6));
   a_last: assert property (@(posedge clk) disable iff (!rst_n)
      (out_valid & out_ready & out_last) |-> (open_cnt != 2'd0));

endmodule
